// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port between NREQ
//   requesters. A requester wins a grant, then streams up to MAX_BURST words
//   straight into the FIFO. The burst pauses while the FIFO is full. It ends
//   on a word flagged req_last, on reaching MAX_BURST words, or when the
//   requester drops req. A new burst never starts while fifo_almost_full is set.
//
// Ports
//   wr_clk           write-domain clock, rising edge
//   clear            synchronous active-high reset (overrides everything)
//   req[i]           requester i has data
//   req_data         packed words, slice i = req_data[i*WIDTH +: WIDTH]
//   req_last[i]      current word of requester i ends its burst
//   gnt              registered one-hot grant, zero when idle
//   accept[i]        word of requester i consumed this cycle (combinational)
//   fifo_din         FIFO write data
//   fifo_wr_en       FIFO write enable
//   fifo_full        FIFO full, stalls the burst
//   fifo_almost_full FIFO almost full, blocks new grants only
//   burst_cnt        words transferred in the current burst
//   busy             high while a burst is in progress
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                          wr_clk,
  input  logic                          clear,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*WIDTH-1:0]         req_data,
  input  logic [NREQ-1:0]               req_last,
  output logic [NREQ-1:0]               gnt,
  output logic [NREQ-1:0]               accept,
  output logic [WIDTH-1:0]              fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic [$clog2(MAX_BURST):0]    burst_cnt,
  output logic                          busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [NREQ-1:0]    gnt_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [IDX_W-1:0]   last_winner, last_winner_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   winner;
  logic               found;
  logic               xfer;
  logic               burst_end;

  // Register stage: control state only
  always_ff @(posedge wr_clk) begin
    if (clear) begin
      state       <= IDLE;
      gnt         <= '0;
      gidx        <= '0;
      burst_cnt   <= '0;
      last_winner <= IDX_W'(NREQ - 1);
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      gidx        <= gidx_nxt;
      burst_cnt   <= cnt_nxt;
      last_winner <= last_winner_nxt;
    end
  end

  // Next-state and write-port outputs
  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt;
    gidx_nxt        = gidx;
    cnt_nxt         = burst_cnt;
    last_winner_nxt = last_winner;
    accept          = '0;
    fifo_wr_en      = 1'b0;
    fifo_din        = '0;
    xfer            = 1'b0;
    burst_end       = 1'b0;
    cand            = '0;
    winner          = '0;
    found           = 1'b0;

    // Round-robin search starting just after the previous winner, so the
    // requester that finished most recently has the lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_winner) + k) % NREQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    case (state)
      IDLE: begin
        if (found && !fifo_almost_full) begin
          state_nxt       = BURST;
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          gidx_nxt        = winner;
          cnt_nxt         = '0;
        end
      end
      BURST: begin
        // Data of the granted requester is presented even when stalled.
        fifo_din     = req_data[gidx*WIDTH +: WIDTH];
        xfer         = req[gidx] & ~fifo_full;
        fifo_wr_en   = xfer;
        accept[gidx] = xfer;
        // A dropped req abandons the burst without consuming a word.
        burst_end = ~req[gidx] |
                    (xfer & (req_last[gidx] | (burst_cnt == CNT_W'(MAX_BURST - 1))));
        if (burst_end) begin
          state_nxt       = IDLE;
          gnt_nxt         = '0;
          cnt_nxt         = '0;
          last_winner_nxt = gidx;
        end else if (xfer) begin
          cnt_nxt = burst_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase

    // clear blanks the write port in the same cycle it is applied.
    if (clear) begin
      accept     = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
    end
  end

  assign busy = (state == BURST);

endmodule
